// File: rtl/cache_cmd_scheduler_pkg.sv
// Shared definitions for the trace-command scheduler:
// command codes, data-cache op encodings and FSM states.
package mypkg;

    localparam int INDEX_BITS_DEF  = 14;
    localparam int OFFSET_BITS_DEF = 6;

    localparam logic [3:0] CMD_READ       = 4'd0;
    localparam logic [3:0] CMD_WRITE      = 4'd1;
    localparam logic [3:0] CMD_I_FETCH    = 4'd2;
    localparam logic [3:0] CMD_L2_INVAL   = 4'd3;
    localparam logic [3:0] CMD_L2_DATA_RQ = 4'd4;
    localparam logic [3:0] CMD_CLR        = 4'd8;
    localparam logic [3:0] CMD_PRINT      = 4'd9;

    localparam logic [2:0] OP_READ        = 3'd0;
    localparam logic [2:0] OP_WRITE       = 3'd1;
    localparam logic [2:0] OP_SNOOP_INVAL = 3'd3;
    localparam logic [2:0] OP_SNOOP_DATA  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_D_REQ,
        S_D_WAIT,
        S_I_REQ,
        S_I_WAIT,
        S_CLEAR,
        S_PRINT
    } state_t;

    function automatic logic [2:0] d_op(input logic [3:0] code);
        logic [2:0] op;
        op = OP_READ;
        unique case (code)
            CMD_WRITE:      op = OP_WRITE;
            CMD_L2_INVAL:   op = OP_SNOOP_INVAL;
            CMD_L2_DATA_RQ: op = OP_SNOOP_DATA;
            default:        op = OP_READ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/cache_cmd_scheduler_clr_sweeper.sv
// Walks every set index once after a start pulse, driving the
// clear strobe; done marks the final index.
module cache_clr_sweeper
    import mypkg::*;
#(
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  clr_en,
    output logic [INDEX_BITS-1:0] clr_index,
    output logic                  done
);

    localparam logic [INDEX_BITS-1:0] LAST = '1;

    logic                  active_q;
    logic [INDEX_BITS-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            idx_q    <= '0;
        end else if (active_q) begin
            if (idx_q == LAST) begin
                active_q <= 1'b0;
                idx_q    <= '0;
            end else begin
                idx_q <= idx_q + 1'b1;
            end
        end else if (start) begin
            active_q <= 1'b1;
            idx_q    <= '0;
        end
    end

    assign clr_en    = active_q;
    assign clr_index = idx_q;
    assign done      = active_q && (idx_q == LAST);

endmodule

// File: rtl/cache_cmd_scheduler.sv
// Trace-command sequencer: one command at a time to the data or
// instruction cache, plus local clear/print handling and a watchdog.
module cache_cmd_scheduler
    import mypkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int INDEX_BITS  = INDEX_BITS_DEF,
    parameter int OFFSET_BITS = OFFSET_BITS_DEF,
    parameter int TIMEOUT     = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [3:0]            cmd_code,
    input  logic [ADDR_W-1:0]     cmd_addr,
    output logic                  d_req_valid,
    input  logic                  d_req_ready,
    output logic [2:0]            d_req_op,
    output logic [ADDR_W-1:0]     d_req_addr,
    input  logic                  d_done,
    output logic                  i_req_valid,
    input  logic                  i_req_ready,
    output logic [ADDR_W-1:0]     i_req_addr,
    input  logic                  i_done,
    output logic                  clr_en,
    output logic [INDEX_BITS-1:0] clr_index,
    output logic                  clr_stats,
    output logic                  print_req,
    input  logic                  print_done,
    output logic                  err_illegal,
    output logic                  err_timeout,
    output logic                  busy,
    output logic [31:0]           cmd_count
);

    localparam int             WD_W    = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    if (INDEX_BITS + OFFSET_BITS > ADDR_W) begin : g_bad_geometry
        $error("index and offset fields exceed the address width");
    end

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        op_q;
    logic [WD_W-1:0]   wd_q;
    logic [31:0]       count_q;
    logic              illegal_q, timeout_q, print_q;
    logic              is_d, is_i, is_clr, is_prt, legal;
    logic              accept, timed, expired, tmo, sweep_done;

    always_comb begin
        is_d   = 1'b0;
        is_i   = 1'b0;
        is_clr = 1'b0;
        is_prt = 1'b0;
        unique case (1'b1)
            (cmd_code == CMD_READ),
            (cmd_code == CMD_WRITE),
            (cmd_code == CMD_L2_INVAL),
            (cmd_code == CMD_L2_DATA_RQ): is_d   = 1'b1;
            (cmd_code == CMD_I_FETCH):    is_i   = 1'b1;
            (cmd_code == CMD_CLR):        is_clr = 1'b1;
            (cmd_code == CMD_PRINT):      is_prt = 1'b1;
            default: ;
        endcase
    end

    assign legal   = is_d | is_i | is_clr | is_prt;
    assign accept  = (state_q == S_IDLE) && cmd_valid;
    assign timed   = (state_q == S_D_REQ) || (state_q == S_D_WAIT) ||
                     (state_q == S_I_REQ) || (state_q == S_I_WAIT) ||
                     (state_q == S_PRINT);
    assign expired = timed && (wd_q == WD_LAST);

    // Progress always beats the watchdog in the same cycle.
    always_comb begin
        state_d = state_q;
        tmo     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_d)        state_d = S_D_REQ;
                    else if (is_i)   state_d = S_I_REQ;
                    else if (is_clr) state_d = S_CLEAR;
                    else if (is_prt) state_d = S_PRINT;
                end
            end
            S_D_REQ: begin
                if (d_req_ready) state_d = S_D_WAIT;
                else if (expired) begin
                    state_d = S_IDLE;
                    tmo     = 1'b1;
                end
            end
            S_D_WAIT: begin
                if (d_done) state_d = S_IDLE;
                else if (expired) begin
                    state_d = S_IDLE;
                    tmo     = 1'b1;
                end
            end
            S_I_REQ: begin
                if (i_req_ready) state_d = S_I_WAIT;
                else if (expired) begin
                    state_d = S_IDLE;
                    tmo     = 1'b1;
                end
            end
            S_I_WAIT: begin
                if (i_done) state_d = S_IDLE;
                else if (expired) begin
                    state_d = S_IDLE;
                    tmo     = 1'b1;
                end
            end
            S_CLEAR: begin
                if (sweep_done) state_d = S_IDLE;
            end
            S_PRINT: begin
                if (print_done) state_d = S_IDLE;
                else if (expired) begin
                    state_d = S_IDLE;
                    tmo     = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd_q      <= '0;
            addr_q    <= '0;
            op_q      <= OP_READ;
            count_q   <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            print_q   <= 1'b0;
        end else begin
            if ((state_d != state_q) || !timed) wd_q <= '0;
            else                                wd_q <= wd_q + 1'b1;
            illegal_q <= accept && !legal;
            timeout_q <= tmo;
            print_q   <= accept && is_prt;
            if (accept && legal) begin
                addr_q  <= cmd_addr;
                op_q    <= d_op(cmd_code);
                count_q <= count_q + 1'b1;
            end
        end
    end

    cache_clr_sweeper #(
        .INDEX_BITS(INDEX_BITS)
    ) u_sweeper (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (accept && is_clr),
        .clr_en   (clr_en),
        .clr_index(clr_index),
        .done     (sweep_done)
    );

    assign cmd_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign d_req_valid = (state_q == S_D_REQ);
    assign d_req_op    = op_q;
    assign d_req_addr  = addr_q;
    assign i_req_valid = (state_q == S_I_REQ);
    assign i_req_addr  = addr_q;
    assign clr_stats   = sweep_done;
    assign print_req   = print_q;
    assign err_illegal = illegal_q;
    assign err_timeout = timeout_q;
    assign cmd_count   = count_q;

endmodule
